// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, bubble word, fetch FSM states and the
// IF/ID pipeline record.
package cpu_pkg;

   localparam logic [5:0] RFORMAT = 6'b000000;
   localparam logic [5:0] LW      = 6'b100011;
   localparam logic [5:0] SW      = 6'b101011;
   localparam logic [5:0] BEQ     = 6'b000100;
   localparam logic [5:0] HALT    = 6'b111111;

   localparam logic [31:0] NOP_INSTR = 32'h0;

   typedef enum logic {
      FETCH_RUN,
      FETCH_HALTED
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc_plus4;
      logic        valid;
   } ifid_t;

endpackage

// File: rtl/imem_1w1r.sv
// Word memory with combinational read and synchronous write; contents are
// never reset, so a read in the cycle of a write returns the old word.
module imem_1w1r #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned WIDTH = 32,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage with IF/ID register, load-use stall, branch flush
// and a RUN/HALTED fetch FSM that stops on the HALT opcode.
module if_fetch_stage
   import cpu_pkg::*;
#(
   parameter int unsigned  IMEM_DEPTH  = 32,
   parameter logic [31:0]  RESET_PC    = 32'h0000_0000,
   parameter logic [5:0]   HALT_OPCODE = HALT,
   localparam int unsigned AW          = $clog2(IMEM_DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall_i,
   input  logic          flush_i,
   input  logic [31:0]   branch_target_i,
   input  logic          imem_we_i,
   input  logic [AW-1:0] imem_waddr_i,
   input  logic [31:0]   imem_wdata_i,
   output logic [31:0]   pc_o,
   output logic [31:0]   instruction_ifid_o,
   output logic [31:0]   pc_plus4_ifid_o,
   output logic          valid_ifid_o,
   output logic          halted_o,
   output logic [31:0]   fetch_count_o
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   ifid_t        ifid_q, ifid_d;
   logic [31:0]  count_q, count_d;
   logic [31:0]  word;
   logic [31:0]  pc_plus4;
   logic         is_halt;
   logic         fetch_en;

   imem_1w1r #(.DEPTH(IMEM_DEPTH), .WIDTH(32)) u_imem (
      .clk     (clk),
      .we_i    (imem_we_i),
      .waddr_i (imem_waddr_i),
      .wdata_i (imem_wdata_i),
      .raddr_i (pc_q[AW+1:2]),
      .rdata_o (word)
   );

   assign pc_plus4 = pc_q + 32'd4;
   assign is_halt  = (word[31:26] == HALT_OPCODE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = FETCH_RUN;
      end else if (!stall_i && state_q == FETCH_RUN && is_halt) begin
         state_d = FETCH_HALTED;
      end
   end

   always_comb begin
      halted_o = (state_q == FETCH_HALTED);
      fetch_en = (state_q == FETCH_RUN);
   end

   // Priority flush > stall > halted > normal; rst is applied in the register.
   always_comb begin
      pc_d    = pc_q;
      ifid_d  = ifid_q;
      count_d = count_q;
      if (flush_i) begin
         pc_d   = branch_target_i;
         ifid_d = '0;
      end else if (stall_i) begin
         pc_d = pc_q;
      end else if (!fetch_en) begin
         ifid_d = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};
      end else begin
         ifid_d  = '{instr: word, pc_plus4: pc_plus4, valid: 1'b1};
         count_d = count_q + 32'd1;
         pc_d    = is_halt ? pc_q : pc_plus4;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         ifid_q  <= '0;
         count_q <= '0;
      end else begin
         pc_q    <= pc_d;
         ifid_q  <= ifid_d;
         count_q <= count_d;
      end
   end

   assign pc_o               = pc_q;
   assign instruction_ifid_o = ifid_q.instr;
   assign pc_plus4_ifid_o    = ifid_q.pc_plus4;
   assign valid_ifid_o       = ifid_q.valid;
   assign fetch_count_o      = count_q;

endmodule
